// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone-classic arbiter in front of one memory slave, with a stall timeout.
// Define ARB_RR_EN for round-robin on contention; otherwise the data port always wins.
module wb_mem_arbiter #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          TIMEOUT  = 16,
  parameter logic [DATA_W-1:0]    ERR_DATA = 32'hDEADBEEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              instr_stb_i,
  input  logic              instr_we_i,
  output logic [DATA_W-1:0] instr_data_o,
  output logic              instr_ack_o,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_data_i,
  input  logic              data_stb_i,
  input  logic              data_we_i,
  output logic [DATA_W-1:0] data_data_o,
  output logic              data_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              timeout_err_o
);

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit              TmoEn   = (TIMEOUT != 0);

  typedef enum logic [1:0] {StIdle, StBusI, StBusD} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              pick_data;
  logic              sel_data;
  logic              gnt_stb;
  logic              gnt_ack;
  logic [DATA_W-1:0] gnt_data;

`ifdef ARB_RR_EN
  // Set when the most recent grant went to the data port.
  logic last_data_q, last_data_d;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= StIdle;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    pick_data     = 1'b0;
    sel_data      = (state_q == StBusD);
    gnt_stb       = 1'b0;
    gnt_ack       = 1'b0;
    gnt_data      = '0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    mem_stb_o     = 1'b0;
    mem_we_o      = 1'b0;
    timeout_err_o = 1'b0;
`ifdef ARB_RR_EN
    last_data_d   = last_data_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (data_stb_i && instr_stb_i) begin
`ifdef ARB_RR_EN
          pick_data = !last_data_q;
`else
          pick_data = 1'b1;
`endif
        end else begin
          pick_data = data_stb_i;
        end
        if (data_stb_i || instr_stb_i) begin
          state_d   = pick_data ? StBusD : StBusI;
          tmo_cnt_d = '0;
`ifdef ARB_RR_EN
          last_data_d = pick_data;
`endif
        end
      end
      StBusI, StBusD: begin
        gnt_stb    = sel_data ? data_stb_i : instr_stb_i;
        mem_addr_o = sel_data ? data_addr_i : instr_addr_i;
        mem_we_o   = sel_data ? data_we_i : instr_we_i;
        mem_data_o = sel_data ? data_data_i : '0;
        mem_stb_o  = gnt_stb;
        gnt_data   = mem_data_i;
        if (!gnt_stb) begin
          // Master abandoned the cycle: release the bus silently.
          state_d = StIdle;
        end else if (mem_ack_i) begin
          gnt_ack = 1'b1;
          state_d = StIdle;
        end else if (TmoEn && (tmo_cnt_q == CntLast)) begin
          mem_stb_o     = 1'b0;
          gnt_ack       = 1'b1;
          gnt_data      = ERR_DATA;
          timeout_err_o = 1'b1;
          state_d       = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    instr_ack_o  = (state_q == StBusI) && gnt_ack;
    data_ack_o   = (state_q == StBusD) && gnt_ack;
    instr_data_o = (state_q == StBusI) ? gnt_data : '0;
    data_data_o  = (state_q == StBusD) ? gnt_data : '0;
  end

endmodule
